// File: rtl/mac_vec_seq.sv
// Vector multiply-accumulate sequencer: accumulates a*b over up to LEN operand
// pairs (or until in_last), then holds the sum, beat count and overflow flag for the sink.
module mac_vec_seq #(
  parameter int BWOP = 32,
  parameter int NAB  = 0,
  parameter int LEN  = 8,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BWOP-1:0] in_a,
  input  logic [BWOP-1:0] in_b,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BWOP-1:0] out_c,
  output logic [CW-1:0]   out_cnt,
  output logic            out_ovf
);

  // Handshake: a pair transfers on a rising clk edge where in_valid & in_ready;
  // a result transfers where out_valid & out_ready. in_ready/out_valid depend on
  // state only, so neither side may wait on the other combinationally.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BWOP-1:0] NAB_MASK = {BWOP{1'b1}} << NAB;

  state_t            state;
  state_t            state_nxt;
  logic [BWOP-1:0]   acc;
  logic [CW-1:0]     cnt;
  logic              ovf;

  logic              accept;
  logic              handoff;
  logic [2*BWOP-1:0] full_prod;
  logic [BWOP-1:0]   prod;
  logic              p_ovf;
  logic [BWOP:0]     sum;
  logic [CW-1:0]     cnt_inc;
  logic              close_acc;

  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;
  assign full_prod = {{BWOP{1'b0}}, in_a} * {{BWOP{1'b0}}, in_b};
  assign prod      = full_prod[BWOP-1:0] & NAB_MASK;
  assign p_ovf     = |full_prod[2*BWOP-1:BWOP];
  assign sum       = {1'b0, acc} + {1'b0, prod};
  assign cnt_inc   = cnt + 1'b1;
  assign close_acc = in_last || (cnt_inc == CW'(LEN));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (in_last || LEN == 1) ? DONE : ACC;
      ACC:  if (accept && close_acc) state_nxt = DONE;
      DONE: if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state; result fields read as zero until DONE
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_c     = '0;
    out_cnt   = '0;
    out_ovf   = 1'b0;
    if (state == DONE) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
      out_c     = acc;
      out_cnt   = cnt;
      out_ovf   = ovf;
    end
  end

  // Accumulator datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= prod;
          cnt <= CW'(1);
          ovf <= p_ovf;
        end
        ACC: if (accept) begin
          acc <= sum[BWOP-1:0];
          cnt <= cnt_inc;
          ovf <= ovf | p_ovf | sum[BWOP];
        end
        DONE: if (handoff) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
        default: begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end
      endcase
    end
  end

endmodule
